// File: rtl/vp_seq_pkg.sv
// Shared types and constants for the load-value speculation sequencer.
package vp_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SNAP,
    SPEC,
    RESTORE,
    REDIRECT
  } vp_state_e;

  localparam int REG_IDX_W = 5;
  localparam int WORD_OFS  = 2;

endpackage

// File: rtl/restore_walker.sv
// Register-file restore walker: steps the restore index 0..NUM_REGS-1, one per cycle.
module restore_walker
  import vp_seq_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 we,
  output logic [REG_IDX_W-1:0] idx,
  output logic                 done
);

  localparam logic [REG_IDX_W-1:0] LAST_IDX = REG_IDX_W'(NUM_REGS - 1);

  logic run;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run <= 1'b0;
      idx <= '0;
    end else if (start) begin
      run <= 1'b1;
      idx <= '0;
    end else if (run) begin
      // idx parks at 0 once the walk ends so it reads 0 outside RESTORE
      if (idx == LAST_IDX) begin
        run <= 1'b0;
        idx <= '0;
      end else begin
        idx <= idx + REG_IDX_W'(1);
      end
    end
  end

  assign we   = run;
  assign done = run & (idx == LAST_IDX);

endmodule

// File: rtl/vp_recovery_sequencer.sv
// Load-value speculation sequencer around a D-cache read miss.
// Define VP_STATS_EN to add saturating stat_correct/stat_wrong/stat_timeout counters.
module vp_recovery_sequencer
  import vp_seq_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REGS     = 32,
  parameter int SPEC_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  miss_valid,
  input  logic [DATA_WIDTH-1:0] miss_pc,
  input  logic [DATA_WIDTH-1:0] miss_addr,
  input  logic                  pred_valid,
  input  logic [DATA_WIDTH-1:0] pred_data,
  output logic                  miss_accept,
  output logic                  snap_req,
  input  logic                  snap_done,
  input  logic                  fill_valid,
  input  logic [DATA_WIDTH-1:0] fill_addr,
  input  logic [DATA_WIDTH-1:0] fill_data,
  input  logic                  spec_mem_access,
  output logic                  use_pred,
  output logic [DATA_WIDTH-1:0] pred_out,
  output logic                  spec_stall,
  output logic                  recover,
  output logic                  rf_restore_we,
  output logic [REG_IDX_W-1:0]  rf_restore_idx,
  output logic                  load_pc_we,
  output logic [DATA_WIDTH-1:0] load_pc_new,
  output logic                  train_valid,
  output logic [DATA_WIDTH-1:0] train_pc,
  output logic [DATA_WIDTH-1:0] train_data,
  output logic                  busy
`ifdef VP_STATS_EN
  ,
  output logic [31:0]           stat_correct,
  output logic [31:0]           stat_wrong,
  output logic [31:0]           stat_timeout
`endif
);

  localparam int CNT_W = $clog2(SPEC_TIMEOUT);
  localparam int TAG_W = DATA_WIDTH - WORD_OFS;

  vp_state_e             state, next_state;
  logic [DATA_WIDTH-1:0] pc_q, pred_q, pend_data_q, train_data_q, match_data;
  logic [TAG_W-1:0]      tag_q;
  logic [CNT_W-1:0]      to_cnt;
  logic                  pend_q, train_valid_q;
  logic                  fill_match, spec_match, spec_correct, spec_wrong, spec_timeout;
  logic                  walk_start, walk_done;
  logic                  addr_lsb_unused;

  assign addr_lsb_unused = ^{fill_addr[WORD_OFS-1:0], miss_addr[WORD_OFS-1:0]};

  // A fill that arrived during SNAP is held in pend_q and wins on the first SPEC cycle
  assign fill_match   = fill_valid & (fill_addr[DATA_WIDTH-1:WORD_OFS] == tag_q);
  assign spec_match   = (state == SPEC) & (pend_q | fill_match);
  assign match_data   = pend_q ? pend_data_q : fill_data;
  assign spec_correct = spec_match & (match_data == pred_q);
  assign spec_wrong   = spec_match & (match_data != pred_q);
  assign spec_timeout = (state == SPEC) & ~spec_match & (to_cnt == CNT_W'(SPEC_TIMEOUT - 1));
  assign walk_start   = spec_wrong | spec_timeout;

  assign miss_accept  = miss_valid & pred_valid & (state == IDLE);

  always_comb begin
    next_state = state;
    snap_req   = 1'b0;
    use_pred   = 1'b0;
    spec_stall = 1'b0;
    load_pc_we = 1'b0;
    case (state)
      IDLE: if (miss_accept) next_state = SNAP;
      SNAP: begin
        snap_req   = 1'b1;
        spec_stall = 1'b1;
        if (snap_done) next_state = SPEC;
      end
      SPEC: begin
        use_pred   = 1'b1;
        spec_stall = spec_mem_access;
        if (spec_correct)    next_state = IDLE;
        else if (walk_start) next_state = RESTORE;
      end
      RESTORE: begin
        spec_stall = 1'b1;
        if (walk_done) next_state = REDIRECT;
      end
      REDIRECT: begin
        load_pc_we = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      pc_q          <= '0;
      tag_q         <= '0;
      pred_q        <= '0;
      to_cnt        <= '0;
      pend_q        <= 1'b0;
      pend_data_q   <= '0;
      train_valid_q <= 1'b0;
      train_data_q  <= '0;
    end else begin
      state <= next_state;
      if (miss_accept) begin
        pc_q   <= miss_pc;
        tag_q  <= miss_addr[DATA_WIDTH-1:WORD_OFS];
        pred_q <= pred_data;
      end
      if (state != SPEC)    to_cnt <= '0;
      else if (!spec_stall) to_cnt <= to_cnt + CNT_W'(1);
      if (state == SNAP) begin
        if (fill_match && !pend_q) begin
          pend_q      <= 1'b1;
          pend_data_q <= fill_data;
        end
      end else begin
        pend_q <= 1'b0;
      end
      train_valid_q <= spec_match;
      if (spec_match) train_data_q <= match_data;
    end
  end

  restore_walker #(.NUM_REGS(NUM_REGS)) u_walker (
    .clk   (clk),
    .rst_n (rst_n),
    .start (walk_start),
    .we    (rf_restore_we),
    .idx   (rf_restore_idx),
    .done  (walk_done)
  );

  assign recover     = (state == RESTORE) & (rf_restore_idx == '0);
  assign busy        = (state != IDLE);
  assign pred_out    = pred_q;
  assign load_pc_new = pc_q;
  assign train_pc    = pc_q;
  assign train_valid = train_valid_q;
  assign train_data  = train_data_q;

`ifdef VP_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_correct <= '0;
      stat_wrong   <= '0;
      stat_timeout <= '0;
    end else begin
      if (spec_correct && stat_correct != '1) stat_correct <= stat_correct + 32'd1;
      if (spec_wrong   && stat_wrong   != '1) stat_wrong   <= stat_wrong + 32'd1;
      if (spec_timeout && stat_timeout != '1) stat_timeout <= stat_timeout + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vp_recovery_sequencer.sv
// Randomized bench for vp_recovery_sequencer with a transaction-level timeline model.
module tb_vp_recovery_sequencer;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          miss_valid, pred_valid, snap_done, fill_valid, spec_mem_access;
  logic [DW-1:0] miss_pc, miss_addr, pred_data, fill_addr, fill_data;
  logic          miss_accept, snap_req, use_pred, spec_stall, recover;
  logic          rf_restore_we, load_pc_we, train_valid, busy;
  logic [4:0]    rf_restore_idx;
  logic [DW-1:0] pred_out, load_pc_new, train_pc, train_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  vp_recovery_sequencer #(.DATA_WIDTH(DW), .NUM_REGS(NR), .SPEC_TIMEOUT(TO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .miss_valid      (miss_valid),
    .miss_pc         (miss_pc),
    .miss_addr       (miss_addr),
    .pred_valid      (pred_valid),
    .pred_data       (pred_data),
    .miss_accept     (miss_accept),
    .snap_req        (snap_req),
    .snap_done       (snap_done),
    .fill_valid      (fill_valid),
    .fill_addr       (fill_addr),
    .fill_data       (fill_data),
    .spec_mem_access (spec_mem_access),
    .use_pred        (use_pred),
    .pred_out        (pred_out),
    .spec_stall      (spec_stall),
    .recover         (recover),
    .rf_restore_we   (rf_restore_we),
    .rf_restore_idx  (rf_restore_idx),
    .load_pc_we      (load_pc_we),
    .load_pc_new     (load_pc_new),
    .train_valid     (train_valid),
    .train_pc        (train_pc),
    .train_data      (train_data),
    .busy            (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [8:0] ctl_vec();
    return {miss_accept, snap_req, use_pred, spec_stall, recover,
            rf_restore_we, load_pc_we, train_valid, busy};
  endfunction

  task automatic quiet_inputs();
    miss_valid = 1'b0; pred_valid = 1'b0; snap_done = 1'b0;
    fill_valid = 1'b0; spec_mem_access = 1'b0;
    miss_pc = '0; miss_addr = '0; pred_data = '0; fill_addr = '0; fill_data = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 64'(ctl_vec()), 64'd0);
    chk({tag, "_idx"}, 64'(rf_restore_idx), 64'd0);
    chk({tag, "_pred_out"}, 64'(pred_out), 64'd0);
    chk({tag, "_pc_new"}, 64'(load_pc_new), 64'd0);
    chk({tag, "_train_pc"}, 64'(train_pc), 64'd0);
    chk({tag, "_train_data"}, 64'(train_data), 64'd0);
  endtask

  // Timeline relative to the accept cycle t=0: SNAP for 1..ds+1, SPEC from s0 = ds+2.
  // A fill at f ends speculation at max(f, s0); otherwise the timeout fires once
  // TO-1 unstalled SPEC cycles have elapsed. Recovery occupies NR restore cycles
  // plus one redirect cycle after the end-of-speculation cycle e.
  task automatic run_txn(input logic [DW-1:0] pc, input logic [DW-1:0] addr,
                         input logic [DW-1:0] pred, input bit pv, input int ds,
                         input int f, input bit fill_ok, input bit sma_on,
                         input bit dis_on, input bit noise, input int rst_idx);
    int s0, m, tc, e, cnt, end_busy, total, rst_at;
    bit match, correct;
    bit sma[256];
    logic [DW-1:0] fdata;
    bit acc, snap, spec, rest, redir, train;
    logic [8:0] ev;

    s0 = ds + 2;
    for (int i = 0; i < 256; i++) sma[i] = sma_on && ($urandom_range(0, 2) == 0);
    m = (f < 0) ? 1000 : ((f < s0) ? s0 : f);
    cnt = 0;
    tc  = s0;
    while (cnt != TO - 1 && tc < 250) begin
      if (!sma[tc]) cnt++;
      tc++;
    end
    match    = (m <= tc);
    e        = match ? m : tc;
    correct  = match && fill_ok;
    end_busy = correct ? e : e + NR + 1;
    rst_at   = (rst_idx >= 0 && !correct) ? e + 1 + rst_idx : -1;
    fdata    = fill_ok ? pred : (pred ^ ($urandom() | 32'd1));
    total    = pv ? end_busy + 3 : 4;

    for (int t = 0; t < total; t++) begin
      @(posedge clk);
      #1;
      rst_n           = !(t == rst_at);
      miss_valid      = (t == 0) || (pv && noise && t <= end_busy &&
                        (rst_at < 0 || t <= rst_at) && $urandom_range(0, 3) == 0);
      pred_valid      = (t == 0) ? pv : 1'b1;
      miss_pc         = (t == 0) ? pc : $urandom();
      miss_addr       = (t == 0) ? addr : $urandom();
      pred_data       = (t == 0) ? pred : $urandom();
      snap_done       = pv && (t == ds + 1);
      spec_mem_access = sma[t];
      if (pv && t == f) begin
        fill_valid = 1'b1;
        fill_addr  = {addr[DW-1:2], 2'($urandom_range(0, 3))};
        fill_data  = fdata;
      end else if (pv && dis_on && t >= 1 && $urandom_range(0, 3) == 0) begin
        fill_valid = 1'b1;
        fill_addr  = addr + 32'd4;
        fill_data  = pred;
      end else begin
        fill_valid = 1'b0;
        fill_addr  = $urandom();
        fill_data  = $urandom();
      end
      @(negedge clk);

      if (rst_at >= 0 && t == rst_at + 1) begin
        chk_all_zero("midrst");
        break;
      end

      acc   = pv && (t == 0);
      snap  = pv && t >= 1 && t < s0;
      spec  = pv && t >= s0 && t <= e;
      rest  = pv && !correct && t >= e + 1 && t <= e + NR;
      redir = pv && !correct && t == e + NR + 1;
      train = pv && match && t == e + 1;
      ev = {acc, snap, spec, snap | (spec & sma[t]) | rest, rest && t == e + 1,
            rest, redir, train, snap | spec | rest | redir};
      chk("ctl", 64'(ctl_vec()), 64'(ev));
      if (spec)  chk("pred_out", 64'(pred_out), 64'(pred));
      if (rest)  chk("restore_idx", 64'(rf_restore_idx), 64'(t - e - 1));
      if (redir) chk("load_pc_new", 64'(load_pc_new), 64'(pc));
      if (train) begin
        chk("train_data", 64'(train_data), 64'(fdata));
        chk("train_pc", 64'(train_pc), 64'(pc));
      end
    end

    quiet_inputs();
    rst_n = 1'b1;
    if (rst_at >= 0) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("post_rst_ctl", 64'(ctl_vec()), 64'd0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    quiet_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // pc, addr, pred, pv, ds, f, fill_ok, sma, dis, noise, rst_idx
    run_txn(32'h400, 32'h1000, 32'hAA, 1, 1, 5, 1, 0, 0, 0, -1);  // correct
    run_txn(32'h404, 32'h1000, 32'hAA, 1, 1, 5, 0, 0, 0, 0, -1);  // mispredict
    run_txn(32'h408, 32'h1000, 32'hAA, 0, 1, 5, 1, 0, 0, 0, -1);  // no prediction
    run_txn(32'h40C, 32'h1000, 32'hAA, 1, 0, -1, 1, 0, 0, 0, -1); // timeout
    run_txn(32'h410, 32'h1000, 32'hAA, 1, 0, -1, 1, 1, 1, 0, -1); // stalls + 0x1004 fills
    run_txn(32'h414, 32'h1000, 32'hAA, 1, 0, 5, 0, 0, 0, 0, -1);  // match on timeout cycle
    run_txn(32'h418, 32'h2000, 32'h55, 1, 3, 2, 1, 0, 0, 0, -1);  // fill during SNAP
    run_txn(32'h41C, 32'h1000, 32'hAA, 1, 1, 5, 0, 0, 0, 1, 10);  // reset mid-RESTORE

    for (int n = 0; n < 40; n++) begin
      int ds_r, f_r;
      ds_r = $urandom_range(0, 3);
      f_r  = ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(1, ds_r + TO + 4);
      run_txn($urandom(), $urandom(), $urandom(), ($urandom_range(0, 5) != 0), ds_r, f_r,
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1, 1'b1,
              ($urandom_range(0, 7) == 0) ? $urandom_range(0, NR - 1) : -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
